// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle control unit: FSM state codes,
// ALU operation classes, opcodes and datapath mux select values.
// Optional trap support is enabled by defining RISCV_MC_TRAP_EN.
package mc_ctrl_pkg;

    // Main FSM states. HALT is reachable only when trapping is enabled.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWRITE = 4'd4,
        S_MEMWB    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_JAL      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_HALT     = 4'd11
    } mc_state_t;

    // Operation class the FSM requests from the ALU decoder.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    // Opcodes handled by this core.
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Result mux.
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU A mux.
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    // ALU B mux.
    localparam logic [1:0] SRCB_WDATA = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // Immediate formats.
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // ALU control codes.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Immediate format depends only on the opcode, never on FSM state.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] sel;
        case (op)
            OP_STORE:  sel = IMM_S;
            OP_BRANCH: sel = IMM_B;
            OP_JAL:    sel = IMM_J;
            default:   sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's operation class plus the
// instruction's funct fields onto the ALU control code.
import mc_ctrl_pkg::*;

module alu_decoder (
    input  alu_op_t    alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       op5_i,
    output logic [2:0] alu_control_o
);

    // Only register-register forms with funct7[5] set subtract; addi never does.
    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    3'b000:  alu_control_o = (funct7b5_i & op5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit for the RV32I core. A Moore FSM sequences the
// shared memory/ALU datapath; outputs are purely combinational from the
// current state and the instruction register fields.
// Handshake: none; the datapath follows the controller every cycle, and a
// register whose enable is high captures on the edge that ends the state.
// Build option: define RISCV_MC_TRAP_EN to halt on illegal opcodes.
import mc_ctrl_pkg::*;

module mc_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pcWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] immSrc,
    output logic [2:0] aluControl,
    output logic       halted,
    output logic [3:0] dbg_state
);

    localparam logic [3:0] ST_FETCH    = S_FETCH;
    localparam logic [3:0] ST_DECODE   = S_DECODE;
    localparam logic [3:0] ST_MEMADR   = S_MEMADR;
    localparam logic [3:0] ST_MEMREAD  = S_MEMREAD;
    localparam logic [3:0] ST_MEMWRITE = S_MEMWRITE;
    localparam logic [3:0] ST_MEMWB    = S_MEMWB;
    localparam logic [3:0] ST_EXECUTER = S_EXECUTER;
    localparam logic [3:0] ST_EXECUTEI = S_EXECUTEI;
    localparam logic [3:0] ST_JAL      = S_JAL;
    localparam logic [3:0] ST_ALUWB    = S_ALUWB;
    localparam logic [3:0] ST_BEQ      = S_BEQ;
`ifdef RISCV_MC_TRAP_EN
    localparam logic [3:0] ST_HALT     = S_HALT;
`endif

    logic [3:0] state_q;
    logic [3:0] state_d;

    // Raw per-state controls before reset gating.
    logic       pc_update;
    logic       branch;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic       halt_raw;
    alu_op_t    alu_op;

    // State register; reset lands in FETCH so the first fetch follows release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: opcode dispatch in DECODE, op[5] splits load/store.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = ST_MEMADR;
                    OP_RTYPE:          state_d = ST_EXECUTER;
                    OP_ITYPE:          state_d = ST_EXECUTEI;
                    OP_JAL:            state_d = ST_JAL;
                    OP_BRANCH:         state_d = ST_BEQ;
`ifdef RISCV_MC_TRAP_EN
                    default:           state_d = ST_HALT;
`else
                    // Illegal opcode retires as a two-cycle no-op.
                    default:           state_d = ST_FETCH;
`endif
                endcase
            end
            ST_MEMADR:   state_d = op[5] ? ST_MEMWRITE : ST_MEMREAD;
            ST_MEMREAD:  state_d = ST_MEMWB;
            ST_EXECUTER: state_d = ST_ALUWB;
            ST_EXECUTEI: state_d = ST_ALUWB;
            ST_JAL:      state_d = ST_ALUWB;
            ST_MEMWB:    state_d = ST_FETCH;
            ST_MEMWRITE: state_d = ST_FETCH;
            ST_ALUWB:    state_d = ST_FETCH;
            ST_BEQ:      state_d = ST_FETCH;
`ifdef RISCV_MC_TRAP_EN
            // Sticky until reset.
            ST_HALT:     state_d = ST_HALT;
`endif
            default:     state_d = ST_FETCH;
        endcase
    end

    // Moore output decode; unlisted selects stay at 00.
    always_comb begin
        pc_update     = 1'b0;
        branch        = 1'b0;
        adrSrc        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        halt_raw      = 1'b0;
        resultSrc     = RES_ALUOUT;
        aluSrcA       = SRCA_PC;
        aluSrcB       = SRCB_WDATA;
        alu_op        = ALUOP_ADD;
        case (state_q)
            ST_FETCH: begin
                ir_write_raw = 1'b1;
                aluSrcA      = SRCA_PC;
                aluSrcB      = SRCB_FOUR;
                resultSrc    = RES_ALURESULT;
                pc_update    = 1'b1;
            end
            ST_DECODE: begin
                // Branch/jump target is computed here and parked in ALUOut.
                aluSrcA = SRCA_OLDPC;
                aluSrcB = SRCB_IMM;
            end
            ST_MEMADR: begin
                aluSrcA = SRCA_REG;
                aluSrcB = SRCB_IMM;
            end
            ST_MEMREAD: begin
                adrSrc    = 1'b1;
                resultSrc = RES_ALUOUT;
            end
            ST_MEMWRITE: begin
                adrSrc        = 1'b1;
                resultSrc     = RES_ALUOUT;
                mem_write_raw = 1'b1;
            end
            ST_MEMWB: begin
                resultSrc     = RES_DATA;
                reg_write_raw = 1'b1;
            end
            ST_EXECUTER: begin
                aluSrcA = SRCA_REG;
                aluSrcB = SRCB_WDATA;
                alu_op  = ALUOP_FUNCT;
            end
            ST_EXECUTEI: begin
                aluSrcA = SRCA_REG;
                aluSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            ST_JAL: begin
                // Link value oldPC+4 is computed while PC takes the target.
                aluSrcA   = SRCA_OLDPC;
                aluSrcB   = SRCB_FOUR;
                resultSrc = RES_ALUOUT;
                pc_update = 1'b1;
            end
            ST_ALUWB: begin
                resultSrc     = RES_ALUOUT;
                reg_write_raw = 1'b1;
            end
            ST_BEQ: begin
                aluSrcA   = SRCA_REG;
                aluSrcB   = SRCB_WDATA;
                alu_op    = ALUOP_SUB;
                resultSrc = RES_ALUOUT;
                branch    = 1'b1;
            end
`ifdef RISCV_MC_TRAP_EN
            ST_HALT: begin
                halt_raw = 1'b1;
            end
`endif
            default: begin
                pc_update = 1'b0;
            end
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .op5_i         (op[5]),
        .alu_control_o (aluControl)
    );

    // Write enables and the trap flag are suppressed for the whole reset cycle.
    assign pcWrite   = ~rst & (pc_update | (branch & zero));
    assign memWrite  = ~rst & mem_write_raw;
    assign irWrite   = ~rst & ir_write_raw;
    assign regWrite  = ~rst & reg_write_raw;
`ifdef RISCV_MC_TRAP_EN
    assign halted    = ~rst & halt_raw;
`else
    assign halted    = 1'b0 & halt_raw;
`endif
    assign immSrc    = imm_src_of(op);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed testbench for mc_controller. Each task walks one instruction
// class cycle by cycle against hand-written control vectors.
// Vector layout: {pcWrite, adrSrc, memWrite, irWrite, regWrite,
//                 resultSrc[1:0], aluSrcA[1:0], aluSrcB[1:0], aluControl[2:0], halted}
// Build option: define RISCV_MC_TRAP_EN to expect trap behaviour.
import mc_ctrl_pkg::*;

module tb_mc_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'b0000011;
    logic [2:0] funct3 = 3'b010;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, halted;
    logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc;
    logic [2:0] aluControl;
    logic [3:0] dbg_state;
    logic [14:0] ctl;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [14:0] V_FETCH  = 15'b1_0_0_1_0_10_00_10_000_0;
    localparam logic [14:0] V_DECODE = 15'b0_0_0_0_0_00_01_01_000_0;
    localparam logic [14:0] V_MEMADR = 15'b0_0_0_0_0_00_10_01_000_0;
    localparam logic [14:0] V_ALUWB  = 15'b0_0_0_0_1_00_00_00_000_0;
    localparam logic [14:0] V_HALT   = 15'b0_0_0_0_0_00_00_00_000_1;

    mc_controller dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .pcWrite    (pcWrite),
        .adrSrc     (adrSrc),
        .memWrite   (memWrite),
        .irWrite    (irWrite),
        .regWrite   (regWrite),
        .resultSrc  (resultSrc),
        .aluSrcA    (aluSrcA),
        .aluSrcB    (aluSrcB),
        .immSrc     (immSrc),
        .aluControl (aluControl),
        .halted     (halted),
        .dbg_state  (dbg_state)
    );

    assign ctl = {pcWrite, adrSrc, memWrite, irWrite, regWrite,
                  resultSrc, aluSrcA, aluSrcB, aluControl, halted};

    // Clock
    always #5 clk = ~clk;

    // Advance one cycle and settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] en;
        rst = 1'b1;
        op  = OP_LOAD;
        #1;
        for (int i = 0; i < 3; i++) begin
            en = {pcWrite, memWrite, irWrite, regWrite, halted};
            n_cmp++;
            if (en !== 5'b0) begin
                n_bad++;
                $display("FAIL reset_enables[%0d]: got %b want 00000", i, en);
            end
            if (i < 2) tick();
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== V_FETCH) begin
            n_bad++;
            $display("FAIL reset_first_fetch: got %b want %b", ctl, V_FETCH);
        end
        n_cmp++;
        if (dbg_state !== 4'(S_FETCH)) begin
            n_bad++;
            $display("FAIL reset_state: got %0d want %0d", dbg_state, 4'(S_FETCH));
        end
    endtask

    task automatic test_lw();
        logic [14:0] e [6];
        e = '{V_FETCH, V_DECODE, V_MEMADR,
              15'b0_1_0_0_0_00_00_00_000_0,
              15'b0_0_0_0_1_01_00_00_000_0,
              V_FETCH};
        op = OP_LOAD; funct3 = 3'b010; funct7b5 = 1'b0;
        #1;
        n_cmp++;
        if (immSrc !== 2'b00) begin
            n_bad++;
            $display("FAIL lw_immsrc: got %b want 00", immSrc);
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (ctl !== e[i]) begin
                n_bad++;
                $display("FAIL lw_cycle%0d: got %b want %b", i + 1, ctl, e[i]);
            end
            if (i < 5) tick();
        end
    endtask

    task automatic test_sw();
        logic [14:0] e [5];
        e = '{V_FETCH, V_DECODE, V_MEMADR,
              15'b0_1_1_0_0_00_00_00_000_0,
              V_FETCH};
        op = OP_STORE; funct3 = 3'b010; funct7b5 = 1'b0;
        #1;
        n_cmp++;
        if (immSrc !== 2'b01) begin
            n_bad++;
            $display("FAIL sw_immsrc: got %b want 01", immSrc);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (ctl !== e[i]) begin
                n_bad++;
                $display("FAIL sw_cycle%0d: got %b want %b", i + 1, ctl, e[i]);
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_sub_addi();
        logic [14:0] er [5];
        logic [14:0] ei [5];
        er = '{V_FETCH, V_DECODE, 15'b0_0_0_0_0_00_10_00_001_0, V_ALUWB, V_FETCH};
        ei = '{V_FETCH, V_DECODE, 15'b0_0_0_0_0_00_10_01_000_0, V_ALUWB, V_FETCH};
        op = OP_RTYPE; funct3 = 3'b000; funct7b5 = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (ctl !== er[i]) begin
                n_bad++;
                $display("FAIL sub_cycle%0d: got %b want %b", i + 1, ctl, er[i]);
            end
            if (i < 4) tick();
        end
        op = OP_ITYPE; funct3 = 3'b000; funct7b5 = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (ctl !== ei[i]) begin
                n_bad++;
                $display("FAIL addi_cycle%0d: got %b want %b", i + 1, ctl, ei[i]);
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_alu_decode();
        logic [6:0] ops [7];
        logic [2:0] f3s [7];
        logic       f7s [7];
        logic [2:0] exp [7];
        ops = '{OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_ITYPE, OP_ITYPE};
        f3s = '{3'b000,   3'b010,   3'b110,   3'b111,   3'b001,   3'b111,   3'b110};
        f7s = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b0,     1'b0,     1'b1};
        exp = '{3'b000,   3'b101,   3'b011,   3'b010,   3'b000,   3'b010,   3'b011};
        for (int k = 0; k < 7; k++) begin
            op = ops[k]; funct3 = f3s[k]; funct7b5 = f7s[k];
            tick();
            tick();
            n_cmp++;
            if (aluControl !== exp[k]) begin
                n_bad++;
                $display("FAIL alu_decode[%0d]: got %b want %b", k, aluControl, exp[k]);
            end
            tick();
            tick();
        end
    endtask

    task automatic test_jal();
        logic [14:0] e [5];
        e = '{V_FETCH, V_DECODE, 15'b1_0_0_0_0_00_01_10_000_0, V_ALUWB, V_FETCH};
        op = OP_JAL; funct3 = 3'b000; funct7b5 = 1'b0;
        #1;
        n_cmp++;
        if (immSrc !== 2'b11) begin
            n_bad++;
            $display("FAIL jal_immsrc: got %b want 11", immSrc);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (ctl !== e[i]) begin
                n_bad++;
                $display("FAIL jal_cycle%0d: got %b want %b", i + 1, ctl, e[i]);
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_beq();
        logic [14:0] e [4];
        for (int z = 1; z >= 0; z--) begin
            e = '{V_FETCH, V_DECODE, {z[0], 14'b0_0_0_0_00_10_00_001_0}, V_FETCH};
            op = OP_BRANCH; funct3 = 3'b000; funct7b5 = 1'b0;
            zero = z[0];
            #1;
            n_cmp++;
            if (immSrc !== 2'b10) begin
                n_bad++;
                $display("FAIL beq_immsrc: got %b want 10", immSrc);
            end
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (ctl !== e[i]) begin
                    n_bad++;
                    $display("FAIL beq_z%0d_cycle%0d: got %b want %b", z, i + 1, ctl, e[i]);
                end
                if (i < 3) tick();
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_reset_mid_instr();
        op = OP_LOAD; funct3 = 3'b010; funct7b5 = 1'b0;
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== 15'b0_0_0_0_0_01_00_00_000_0) begin
            n_bad++;
            $display("FAIL midreset_memwb: got %b want %b", ctl, 15'b0_0_0_0_0_01_00_00_000_0);
        end
        tick();
        n_cmp++;
        if (ctl !== 15'b0_0_0_0_0_10_00_10_000_0) begin
            n_bad++;
            $display("FAIL midreset_held: got %b want %b", ctl, 15'b0_0_0_0_0_10_00_10_000_0);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== V_FETCH) begin
            n_bad++;
            $display("FAIL midreset_fetch: got %b want %b", ctl, V_FETCH);
        end
    endtask

    task automatic test_illegal();
        op = 7'b1111111; funct3 = 3'b000; funct7b5 = 1'b0;
        #1;
        n_cmp++;
        if (immSrc !== 2'b00) begin
            n_bad++;
            $display("FAIL illegal_immsrc: got %b want 00", immSrc);
        end
        n_cmp++;
        if (ctl !== V_FETCH) begin
            n_bad++;
            $display("FAIL illegal_cycle1: got %b want %b", ctl, V_FETCH);
        end
        tick();
        n_cmp++;
        if (ctl !== V_DECODE) begin
            n_bad++;
            $display("FAIL illegal_cycle2: got %b want %b", ctl, V_DECODE);
        end
        tick();
`ifdef RISCV_MC_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            if (i == 2) op = OP_LOAD;
            n_cmp++;
            if (ctl !== V_HALT) begin
                n_bad++;
                $display("FAIL halt_cycle%0d: got %b want %b", i + 3, ctl, V_HALT);
            end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== V_FETCH) begin
            n_bad++;
            $display("FAIL halt_release: got %b want %b", ctl, V_FETCH);
        end
`else
        n_cmp++;
        if (ctl !== V_FETCH) begin
            n_bad++;
            $display("FAIL illegal_cycle3: got %b want %b", ctl, V_FETCH);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_sub_addi();
        test_alu_decode();
        test_jal();
        test_beq();
        test_reset_mid_instr();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the RV32I core. It replaces single-cycle decode so that one unified instruction/data memory and one ALU can be shared across cycles. A Moore main FSM steps the datapath through fetch, decode, execute, memory and writeback. It drives every mux select and write enable of the datapath, and a combinational ALU decoder generates `aluControl`.

## Interface
Parameters: none; all encodings live in the shared package.
- `clk` input 1: core clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `op` input 7: `instr[6:0]` from the instruction register.
- `funct3` input 3: `instr[14:12]`.
- `funct7b5` input 1: `instr[30]`.
- `zero` input 1: ALU zero flag.
- `pcWrite` output 1: PC register enable.
- `adrSrc` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `memWrite` output 1: memory write enable.
- `irWrite` output 1: instruction register and oldPC enable.
- `regWrite` output 1: register file write enable.
- `resultSrc` output 2: result mux; 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `aluSrcA` output 2: ALU A mux; 00 = PC, 01 = oldPC, 10 = A register.
- `aluSrcB` output 2: ALU B mux; 00 = WriteData register, 01 = ImmExt, 10 = constant 4.
- `immSrc` output 2: immediate format; 00 = I, 01 = S, 10 = B, 11 = J.
- `aluControl` output 3: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- `halted` output 1: trap indicator; see Configuration.

## Operation
- **FSM states and transitions:**
  - FETCH → DECODE.
  - DECODE dispatches on `op`:
    - 0000011 or 0100011 → MEMADR.
    - 0110011 → EXECUTER.
    - 0010011 → EXECUTEI.
    - 1101111 → JAL.
    - 1100011 → BEQ.
    - Any other opcode → illegal; see Configuration.
  - MEMADR → MEMREAD if `op[5]` = 0, else MEMWRITE.
  - MEMREAD → MEMWB.
  - EXECUTER, EXECUTEI, JAL → ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ → FETCH.
- **Per-state outputs.** Signals not listed are 0; selects not listed are don't-care and drive 00.
  - FETCH: adrSrc=0, irWrite=1, aluSrcA=00, aluSrcB=10, aluOp=add, resultSrc=10, pcUpdate.
  - DECODE: aluSrcA=01, aluSrcB=01, aluOp=add. Precomputes the branch/jump target.
  - MEMADR: aluSrcA=10, aluSrcB=01, aluOp=add.
  - MEMREAD: adrSrc=1, resultSrc=00.
  - MEMWRITE: adrSrc=1, resultSrc=00, memWrite=1.
  - MEMWB: resultSrc=01, regWrite=1.
  - EXECUTER: aluSrcA=10, aluSrcB=00, aluOp=funct.
  - EXECUTEI: aluSrcA=10, aluSrcB=01, aluOp=funct.
  - JAL: aluSrcA=01, aluSrcB=10, aluOp=add, resultSrc=00, pcUpdate.
  - ALUWB: resultSrc=00, regWrite=1.
  - BEQ: aluSrcA=10, aluSrcB=00, aluOp=sub, resultSrc=00, branch.
- **PC enable:** `pcWrite` = pcUpdate | (branch & zero).
- **`immSrc`** is decoded from `op` alone, independent of state: lw/I-ALU → 00, sw → 01, beq → 10, jal → 11, other → 00.
- **ALU decoder:**
  - aluOp add → 000; aluOp sub → 001.
  - aluOp funct, by `funct3`:
    - 000 → sub if `funct7b5` & `op[5]`, else add.
    - 010 → slt.
    - 110 → or.
    - 111 → and.
    - Any other `funct3` → add.

## Timing
- **Reset:**
  - `rst` sampled high → state = FETCH on that edge.
  - While `rst` is high, `pcWrite`, `irWrite`, `regWrite`, `memWrite` and `halted` are forced to 0.
  - The first FETCH executes in the first cycle after `rst` falls.
  - `rst` mid-instruction aborts it; no write enable is asserted in the reset cycle.
- **Output timing:**
  - All outputs are combinational from state and the IR fields; no internal output registers.
  - Datapath registers capture on the edge that ends the state.
- **CPI:** lw 5, sw 4, R-type 4, I-ALU 4, jal 4, beq 3 (taken or not).
- **Branch:** `zero` is sampled only in BEQ; the PC loads ALUOut (the target computed in DECODE) at the end of that cycle.

## Configuration
- **`RISCV_MC_TRAP_EN` defined:**
  - An illegal opcode in DECODE → HALT.
  - HALT is sticky until `rst`: all write enables 0, `halted` = 1.
- **Not defined:**
  - An illegal opcode in DECODE → FETCH; the instruction executes as a 2-cycle NOP.
  - No HALT state exists; `halted` is tied to 0.

## Structure
- **Package `mc_ctrl_pkg`:**
  - State enum `mc_state_t`.
  - aluOp enum: add, sub, funct.
  - Opcode constants.
  - Encodings for the resultSrc, aluSrcA, aluSrcB, immSrc and aluControl selects.
- **Sub-module `alu_decoder`:** combinational; inputs aluOp, `funct3`, `funct7b5`, `op[5]`; output `aluControl`.
- **Top:** FSM state register, next-state logic, Moore output decode, `immSrc` decode.

## Test plan
- **Reset:** hold `rst` 2 cycles with op=0000011 → all write enables 0 and `halted` = 0 throughout; first cycle after release is FETCH with irWrite=1, pcWrite=1.
- **lw** (op=0000011): sequence FETCH→DECODE→MEMADR→MEMREAD→MEMWB→FETCH; regWrite=1 only in cycle 5 with resultSrc=01.
- **sw** (op=0100011): memWrite=1 only in cycle 4, with adrSrc=1; immSrc=01.
- **sub R-type** (op=0110011, funct3=000, funct7b5=1) → aluControl=001 in EXECUTER. **addi** with funct7b5=1 (op=0010011) → aluControl=000.
- **beq** (op=1100011): zero=1 → pcWrite=1 in cycle 3; zero=0 → pcWrite=0; back to FETCH in both cases.
- **Illegal op** 1111111: with `RISCV_MC_TRAP_EN` → `halted` = 1 from cycle 3 and stays 1 until `rst`; without it → FETCH in cycle 3 and no register or memory write.
